sort_stream_ctrl: RTL and testbench

Stream front/back end for the bit-serial bubble-sort array. It accepts K_NUMBERS words on a valid/ready input stream and loads them into the array slots one by one, padding short packets. It then starts the sort, waits for completion or a timeout, snapshots the sorted slots and emits them on a valid/ready output stream in slot order, slot 0 first. Slot 0 holds the smallest value, so the output is ascending.

---
 rtl/sort_pkg.sv | 20 ++
 rtl/sort_snapshot_drain.sv | 67 ++++++
 rtl/sort_stream_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_sort_stream_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared types and constants for the sort stream controller
package sort_pkg;

   typedef enum logic [2:0] {
      LOAD,
      PAD,
      START,
      SORT,
      SETTLE,
      DRAIN
   } state_t;

   // Pad words are all-ones so they sort to the top slots.
   localparam logic [63:0] PAD_WORD = '1;

   function automatic int slot_w(input int k);
      return $clog2(k) + 1;
   endfunction

endpackage

// File: rtl/sort_snapshot_drain.sv
// rtl/sort_snapshot_drain.sv - snapshot of the sorted slots and the output stream drain
module sort_snapshot_drain
   import sort_pkg::*;
#(
   parameter int N_BITS    = 8,
   parameter int K_NUMBERS = 49
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          capture,
   input  logic                          go,
   input  logic [K_NUMBERS*N_BITS-1:0]   slots_i,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [N_BITS-1:0]             m_data,
   output logic                          m_last,
   output logic                          drained
);

   localparam int                IDX_W    = slot_w(K_NUMBERS);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(K_NUMBERS - 1);

   logic [N_BITS-1:0] snap [K_NUMBERS];
   logic [IDX_W-1:0]  didx;
   logic              active;
   logic              beat;

   always_ff @(posedge clk) begin
      if (capture) begin
         for (int i = 0; i < K_NUMBERS; i++) begin
            snap[i] <= slots_i[i*N_BITS +: N_BITS];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         active <= 1'b0;
         didx   <= '0;
      end else if (go) begin
         active <= 1'b1;
         didx   <= '0;
      end else if (beat) begin
         if (didx == LAST_IDX) begin
            active <= 1'b0;
            didx   <= '0;
         end else begin
            didx <= didx + 1'b1;
         end
      end
   end

   always_comb begin
      m_data = '0;
      for (int i = 0; i < K_NUMBERS; i++) begin
         if (didx == i[IDX_W-1:0]) begin
            m_data = snap[i];
         end
      end
   end

   assign beat    = active && m_ready;
   assign m_valid = active;
   assign m_last  = active && (didx == LAST_IDX);
   assign drained = beat && (didx == LAST_IDX);

endmodule

// File: rtl/sort_stream_ctrl.sv
// rtl/sort_stream_ctrl.sv - stream load, sort sequencing and sorted output for the bubble-sort array
module sort_stream_ctrl
   import sort_pkg::*;
#(
   parameter int N_BITS         = 8,
   parameter int K_NUMBERS      = 49,
   parameter int SETTLE_CYCLES  = N_BITS + 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic [N_BITS-1:0]             s_data,
   input  logic                          s_last,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [N_BITS-1:0]             m_data,
   output logic                          m_last,
   output logic [K_NUMBERS-1:0]          load_o,
   output logic [K_NUMBERS*N_BITS-1:0]   writedata_o,
   input  logic [K_NUMBERS*N_BITS-1:0]   readdata_i,
   output logic                          start_o,
   input  logic                          done_i,
   output logic                          abort_o,
   output logic                          busy,
   output logic                          err_len,
   output logic                          err_timeout
);

   localparam int                 IDX_W    = slot_w(K_NUMBERS);
   localparam int                 TCNT_W   = $clog2(TIMEOUT_CYCLES) + 1;
   localparam int                 SCNT_W   = $clog2(SETTLE_CYCLES) + 1;
   localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(K_NUMBERS - 1);
   localparam logic [TCNT_W-1:0]  T_LAST   = TCNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [SCNT_W-1:0]  S_LAST   = SCNT_W'(SETTLE_CYCLES - 1);

   state_t                 state, state_n;
   logic [IDX_W-1:0]       idx;
   logic [TCNT_W-1:0]      tcnt;
   logic [SCNT_W-1:0]      scnt;
   logic                   dropping;
   logic                   accept, wr_en, done_ok, timeout, len_err, capture, drained;
   logic [N_BITS-1:0]      wr_word, wdata_q;
   logic [K_NUMBERS-1:0]   onehot, load_q;
   logic                   start_q, abort_q, err_len_q, err_timeout_q;

   // Overlong-packet tails are swallowed in any state until their s_last beat.
   assign s_ready = !rst && ((state == LOAD) || dropping);
   assign accept  = s_valid && s_ready;
   assign done_ok = done_i && (state == SORT) && (tcnt != '0);
   assign timeout = (state == SORT) && (tcnt == T_LAST) && !done_ok;
   assign len_err = (state == LOAD) && accept && !dropping && (idx == LAST_IDX) && !s_last;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= LOAD;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      wr_en   = 1'b0;
      wr_word = s_data;
      capture = 1'b0;
      case (state)
         LOAD: begin
            if (accept && !dropping) begin
               wr_en = 1'b1;
               if (idx == LAST_IDX) begin
                  state_n = START;
               end else if (s_last) begin
                  state_n = PAD;
               end
            end
         end
         PAD: begin
            wr_en   = 1'b1;
            wr_word = PAD_WORD[N_BITS-1:0];
            if (idx == LAST_IDX) begin
               state_n = START;
            end
         end
         START:  state_n = SORT;
         SORT: begin
            if (done_ok) begin
               state_n = SETTLE;
            end else if (timeout) begin
               state_n = LOAD;
            end
         end
         SETTLE: begin
            if (scnt == S_LAST) begin
               capture = 1'b1;
               state_n = DRAIN;
            end
         end
         DRAIN: begin
            if (drained) begin
               state_n = LOAD;
            end
         end
         default: state_n = LOAD;
      endcase
   end

   always_comb begin
      onehot = '0;
      for (int i = 0; i < K_NUMBERS; i++) begin
         onehot[i] = (idx == i[IDX_W-1:0]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx           <= '0;
         tcnt          <= '0;
         scnt          <= '0;
         dropping      <= 1'b0;
         wdata_q       <= '0;
         load_q        <= '0;
         start_q       <= 1'b0;
         abort_q       <= 1'b0;
         err_len_q     <= 1'b0;
         err_timeout_q <= 1'b0;
      end else begin
         load_q  <= '0;
         start_q <= (state == START);
         abort_q <= timeout;
         if (wr_en) begin
            wdata_q <= wr_word;
            load_q  <= onehot;
         end
         if (state_n == START) begin
            idx <= '0;
         end else if (wr_en && (idx != LAST_IDX)) begin
            idx <= idx + 1'b1;
         end
         if (state == START) begin
            tcnt <= '0;
         end else if ((state == SORT) && (tcnt != '1)) begin
            tcnt <= tcnt + 1'b1;
         end
         if (state != SETTLE) begin
            scnt <= '0;
         end else if (scnt != '1) begin
            scnt <= scnt + 1'b1;
         end
         if (len_err) begin
            dropping <= 1'b1;
         end else if (dropping && accept && s_last) begin
            dropping <= 1'b0;
         end
         // The overlong beat itself enters START, so its flag survives the clear.
         if ((state_n == START) && (state != START)) begin
            err_len_q     <= len_err;
            err_timeout_q <= 1'b0;
         end else if (timeout) begin
            err_timeout_q <= 1'b1;
         end
      end
   end

   sort_snapshot_drain #(
      .N_BITS    (N_BITS),
      .K_NUMBERS (K_NUMBERS)
   ) u_drain (
      .clk     (clk),
      .rst     (rst),
      .capture (capture),
      .go      (capture),
      .slots_i (readdata_i),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_last  (m_last),
      .drained (drained)
   );

   assign load_o      = load_q;
   assign writedata_o = {K_NUMBERS{wdata_q}};
   assign start_o     = start_q;
   assign abort_o     = abort_q;
   assign busy        = !((state == LOAD) && (idx == '0));
   assign err_len     = err_len_q;
   assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_sort_stream_ctrl.sv
// tb/tb_sort_stream_ctrl.sv - self-checking bench for sort_stream_ctrl with a behavioural sort array
module tb_sort_stream_ctrl;

   localparam int N      = 8;
   localparam int K      = 4;
   localparam int SETTLE = N + 4;
   localparam int TMO    = 16;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           s_valid = 1'b0;
   logic           s_ready;
   logic [N-1:0]   s_data = '0;
   logic           s_last = 1'b0;
   logic           m_valid;
   logic           m_ready = 1'b1;
   logic [N-1:0]   m_data;
   logic           m_last;
   logic [K-1:0]   load_o;
   logic [K*N-1:0] writedata_o;
   logic [K*N-1:0] readdata_i;
   logic           start_o;
   logic           done_i = 1'b0;
   logic           abort_o;
   logic           busy;
   logic           err_len;
   logic           err_timeout;

   sort_stream_ctrl #(
      .N_BITS         (N),
      .K_NUMBERS      (K),
      .SETTLE_CYCLES  (SETTLE),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .s_last      (s_last),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .m_last      (m_last),
      .load_o      (load_o),
      .writedata_o (writedata_o),
      .readdata_i  (readdata_i),
      .start_o     (start_o),
      .done_i      (done_i),
      .abort_o     (abort_o),
      .busy        (busy),
      .err_len     (err_len),
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Behavioural array: loads slots, sorts a few cycles after start_o, then pulses done_i.
   logic [N-1:0] arr [K] = '{default: '0};
   logic [N-1:0] tmp [K];
   logic [N-1:0] t8;
   int           sort_cnt = 0;
   bit           done_en = 1'b1;
   assign readdata_i = {arr[3], arr[2], arr[1], arr[0]};

   always @(posedge clk) begin
      done_i <= 1'b0;
      for (int i = 0; i < K; i++) if (load_o[i]) arr[i] <= writedata_o[i*N +: N];
      if (start_o) begin
         sort_cnt <= 4;
      end else if (sort_cnt != 0) begin
         sort_cnt <= sort_cnt - 1;
         if (sort_cnt == 1) begin
            tmp = arr;
            for (int a = 0; a < K - 1; a++)
               for (int b = 0; b < K - 1 - a; b++)
                  if (tmp[b] > tmp[b+1]) begin
                     t8 = tmp[b]; tmp[b] = tmp[b+1]; tmp[b+1] = t8;
                  end
            for (int i = 0; i < K; i++) arr[i] <= tmp[i];
            done_i <= done_en;
         end
      end
   end

   bit          bp = 1'b0;
   logic [3:0]  bp_pat = 4'b1001;
   always @(posedge clk) begin
      #1;
      m_ready = bp ? bp_pat[cyc[1:0]] : 1'b1;
   end

   logic [N-1:0] exp_q [$];
   logic [K-1:0] load_log [$];
   int           load_cyc [$];
   int           acc_log [$];
   int           start_cyc = 0, abort_cyc = 0, done_cyc = 0, mv_rise = 0, beats = 0;
   bit           abort_seen = 1'b0, mv_seen = 1'b0;
   bit           prev_stall = 1'b0, prev_mv = 1'b0, prev_last = 1'b0;
   logic [N-1:0] prev_data = '0;
   logic [N-1:0] e;

   always @(negedge clk) begin
      if (!rst) begin
         if (prev_stall) begin
            check("hold_valid", m_valid, 1);
            check("hold_data", m_data, prev_data);
            check("hold_last", m_last, prev_last);
         end
         if (m_valid && !prev_mv) mv_rise = cyc;
         if (m_valid) mv_seen = 1'b1;
         if (m_valid && m_ready) begin
            beats++;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_beat: got data %0h required no beat", m_data);
            end else begin
               e = exp_q.pop_front();
               check("m_data", m_data, e);
               check("m_last", m_last, exp_q.size() == 0);
            end
         end
         if (load_o != '0) begin
            load_log.push_back(load_o);
            load_cyc.push_back(cyc);
         end
         if (s_valid && s_ready) acc_log.push_back(cyc);
         if (start_o) start_cyc = cyc;
         if (abort_o) begin abort_cyc = cyc; abort_seen = 1'b1; end
         if (done_i) done_cyc = cyc;
      end
      prev_stall = !rst && m_valid && !m_ready;
      prev_mv    = !rst && m_valid;
      prev_data  = m_data;
      prev_last  = m_last;
   end

   typedef struct {
      int           n;
      logic [N-1:0] w [6];
      logic [N-1:0] e [4];
      bit           err;
      bit           bp;
   } vec_t;
   vec_t vecs [6];

   task automatic send_word(input logic [N-1:0] d, input logic l);
      int tries = 0;
      s_valid = 1'b1; s_data = d; s_last = l;
      while (1) begin
         @(negedge clk);
         if (s_ready) break;
         tries++;
         if (tries > 200) begin
            n_cmp++; n_fail++;
            $display("FAIL s_ready_wait: got s_ready 0 for 200 cycles required 1");
            break;
         end
      end
      @(posedge clk); #1;
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic wait_empty(input int budget);
      int c = 0;
      while (exp_q.size() != 0 && c < budget) begin @(posedge clk); c++; end
      check("drain_done", exp_q.size(), 0);
      #1;
   endtask

   task automatic run_vec(input int v);
      int m;
      bp = vecs[v].bp;
      load_log.delete(); load_cyc.delete(); acc_log.delete();
      for (int i = 0; i < 4; i++) exp_q.push_back(vecs[v].e[i]);
      for (int j = 0; j < vecs[v].n; j++) send_word(vecs[v].w[j], j == vecs[v].n - 1);
      wait_empty(400);
      @(negedge clk);
      check("err_len", err_len, vecs[v].err);
      check("busy_idle", busy, 0);
      check("m_valid_idle", m_valid, 0);
      check("load_count", load_log.size(), 4);
      for (int i = 0; i < load_log.size() && i < 4; i++) check("load_onehot", load_log[i], 1 << i);
      m = (vecs[v].n < 4) ? vecs[v].n : 4;
      for (int i = 0; i < m && i < acc_log.size() && i < load_cyc.size(); i++)
         check("load_latency", load_cyc[i] - acc_log[i], 1);
      if (load_cyc.size() > 0) check("start_after_load", start_cyc - load_cyc[load_cyc.size()-1], 1);
      check("settle_latency", mv_rise - done_cyc, SETTLE + 1);
      @(posedge clk); #1;
      bp = 1'b0;
   endtask

   initial begin
      int c;
      int base;
      vecs[0].n = 4; vecs[0].w = '{8'd5, 8'd3, 8'd9, 8'd1, 8'd0, 8'd0};
      vecs[0].e = '{8'd1, 8'd3, 8'd5, 8'd9};       vecs[0].err = 0; vecs[0].bp = 0;
      vecs[1].n = 2; vecs[1].w = '{8'd7, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0};
      vecs[1].e = '{8'd2, 8'd7, 8'd255, 8'd255};   vecs[1].err = 0; vecs[1].bp = 0;
      vecs[2].n = 6; vecs[2].w = '{8'd8, 8'd4, 8'd6, 8'd2, 8'd1, 8'd0};
      vecs[2].e = '{8'd2, 8'd4, 8'd6, 8'd8};       vecs[2].err = 1; vecs[2].bp = 0;
      vecs[3].n = 4; vecs[3].w = '{8'd0, 8'd255, 8'd0, 8'd17, 8'd0, 8'd0};
      vecs[3].e = '{8'd0, 8'd0, 8'd17, 8'd255};    vecs[3].err = 0; vecs[3].bp = 1;
      vecs[4].n = 1; vecs[4].w = '{8'd42, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
      vecs[4].e = '{8'd42, 8'd255, 8'd255, 8'd255}; vecs[4].err = 0; vecs[4].bp = 0;
      vecs[5].n = 3; vecs[5].w = '{8'd10, 8'd30, 8'd20, 8'd0, 8'd0, 8'd0};
      vecs[5].e = '{8'd10, 8'd20, 8'd30, 8'd255};  vecs[5].err = 0; vecs[5].bp = 1;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_s_ready", s_ready, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_last", m_last, 0);
      check("rst_load_o", load_o, 0);
      check("rst_start_o", start_o, 0);
      check("rst_abort_o", abort_o, 0);
      check("rst_busy", busy, 0);
      check("rst_err_len", err_len, 0);
      check("rst_err_timeout", err_timeout, 0);
      check("rst_writedata", writedata_o, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("s_ready_after_rst", s_ready, 1);
      @(posedge clk); #1;

      for (int v = 0; v < 6; v++) run_vec(v);

      // Timeout: the array never reports done.
      done_en = 1'b0; mv_seen = 1'b0; abort_seen = 1'b0;
      send_word(8'd5, 1'b0); send_word(8'd3, 1'b0); send_word(8'd9, 1'b0); send_word(8'd1, 1'b1);
      c = 0;
      while (!abort_seen && c < 100) begin @(posedge clk); c++; end
      #1;
      check("abort_seen", abort_seen, 1);
      check("abort_delay", abort_cyc - start_cyc, TMO);
      @(negedge clk);
      check("abort_pulse", abort_o, 0);
      check("s_ready_after_abort", s_ready, 1);
      check("err_timeout_set", err_timeout, 1);
      check("m_valid_never", mv_seen, 0);
      check("busy_after_abort", busy, 0);
      @(posedge clk); #1;
      done_en = 1'b1;
      run_vec(0);
      check("err_timeout_cleared", err_timeout, 0);

      // Reset in the middle of draining.
      base = beats;
      for (int i = 0; i < 4; i++) exp_q.push_back(vecs[0].e[i]);
      for (int j = 0; j < 4; j++) send_word(vecs[0].w[j], j == 3);
      c = 0;
      while (beats < base + 2 && c < 400) begin @(posedge clk); c++; end
      check("beats_before_rst", beats - base, 2);
      #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("mid_rst_m_valid", m_valid, 0);
      check("mid_rst_s_ready", s_ready, 1);
      check("mid_rst_busy", busy, 0);
      @(posedge clk); #1;
      run_vec(1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish required finish within 40000 cycles");
      $fatal(1, "watchdog");
   end

endmodule
